// File: rtl/wb_arb_pkg.sv
// Shared constants for the regfile writeback arbiter (see regfile_wb_arbiter,
// optional statistics enabled with WB_ARB_STATS_EN).
package wb_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int X0_ADDR        = 0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter. The priority pointer only moves on a
// contested grant and then points at the loser.
module rr_arbiter2
  import wb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output wb_src_e    gnt_src
);

  wb_src_e ptr_q, ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (rst && !stall) begin
      if (req == 2'b11) begin
        if (ptr_q == SRC_LD) begin
          gnt   = 2'b10;
          ptr_d = SRC_ALU;
        end else begin
          gnt   = 2'b01;
          ptr_d = SRC_LD;
        end
      end else if (req[0]) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

  assign gnt_src = gnt[1] ? SRC_LD : SRC_ALU;

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= SRC_ALU;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between the ALU and load writeback paths.
// Define WB_ARB_STATS_EN to add saturating grant/conflict counters.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
`ifdef WB_ARB_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_stall,
  input  logic                  s0_valid,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0] s0_data,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s1_data,
  output logic                  s1_ready,
  output logic                  reg_write,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data
`ifdef WB_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  grant_cnt0,
  output logic [CNT_WIDTH-1:0]  grant_cnt1,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
`endif
);

  logic [1:0]            req, gnt;
  wb_src_e               gnt_src;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

  assign req = {s1_valid, s0_valid};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .stall   (wb_stall),
    .req     (req),
    .gnt     (gnt),
    .gnt_src (gnt_src)
  );

  assign s0_ready = gnt[0];
  assign s1_ready = gnt[1];
  assign xfer     = |gnt;

  // x0 writes are consumed so the source is released, but never enable the regfile.
  always_comb begin
    sel_addr     = (gnt_src == SRC_LD) ? s1_addr : s0_addr;
    sel_data     = (gnt_src == SRC_LD) ? s1_data : s0_data;
    reg_write_d  = xfer && (sel_addr != ADDR_WIDTH'(X0_ADDR));
    write_addr_d = xfer ? sel_addr : write_addr_q;
    write_data_d = xfer ? sel_data : write_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;

`ifdef WB_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [CNT_WIDTH-1:0] grant_cnt1_q, grant_cnt1_d;
  logic [CNT_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    grant_cnt0_d   = grant_cnt0_q;
    grant_cnt1_d   = grant_cnt1_q;
    conflict_cnt_d = conflict_cnt_q;
    if (gnt[0] && grant_cnt0_q != '1)
      grant_cnt0_d = grant_cnt0_q + CNT_WIDTH'(1);
    if (gnt[1] && grant_cnt1_q != '1)
      grant_cnt1_d = grant_cnt1_q + CNT_WIDTH'(1);
    if (req == 2'b11 && !wb_stall && conflict_cnt_q != '1)
      conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_cnt0_q   <= '0;
      grant_cnt1_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt0_q   <= grant_cnt0_d;
      grant_cnt1_q   <= grant_cnt1_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant_cnt0   = grant_cnt0_q;
  assign grant_cnt1   = grant_cnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference model predicts grants
// and the registered write, a monitor compares the write port each cycle.
module tb_regfile_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wb_stall = 1'b0;
  logic          s0_valid = 1'b0, s1_valid = 1'b0;
  logic [AW-1:0] s0_addr = '0, s1_addr = '0;
  logic [DW-1:0] s0_data = '0, s1_data = '0;
  logic          s0_ready, s1_ready;
  logic          reg_write;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
`ifdef WB_ARB_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1, conflict_cnt;
  int            mc0 = 0, mc1 = 0, mcc = 0;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
`ifdef WB_ARB_STATS_EN
    ,
    .CNT_WIDTH  (CW)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_stall   (wb_stall),
    .s0_valid   (s0_valid),
    .s0_addr    (s0_addr),
    .s0_data    (s0_data),
    .s0_ready   (s0_ready),
    .s1_valid   (s1_valid),
    .s1_addr    (s1_addr),
    .s1_data    (s1_data),
    .s1_ready   (s1_ready),
    .reg_write  (reg_write),
    .write_addr (write_addr),
    .write_data (write_data)
`ifdef WB_ARB_STATS_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  // Reference model: which source wins the next tie, and the last accepted write.
  logic          favor_s1 = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_g0 = 1'b0, m_g1 = 1'b0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic st,
                               input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    wr_t e;
    @(negedge clk);
    rst = r; wb_stall = st;
    s0_valid = v0; s0_addr = a0; s0_data = d0;
    s1_valid = v1; s1_addr = a1; s1_data = d1;
    #1;
    m_g0 = 1'b0;
    m_g1 = 1'b0;
    if (r && !st) begin
      if (v0 && v1) begin
        if (favor_s1) m_g1 = 1'b1;
        else          m_g0 = 1'b1;
        favor_s1 = m_g0;
      end else if (v0) begin
        m_g0 = 1'b1;
      end else if (v1) begin
        m_g1 = 1'b1;
      end
    end
    e.we = 1'b0;
    if (!r) begin
      favor_s1 = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else if (m_g0) begin
      m_addr = a0; m_data = d0; e.we = (a0 != 0);
    end else if (m_g1) begin
      m_addr = a1; m_data = d1; e.we = (a1 != 0);
    end
    e.addr = m_addr;
    e.data = m_data;
    checkOutput("s0_ready", DW'(s0_ready), DW'(m_g0));
    checkOutput("s1_ready", DW'(s1_ready), DW'(m_g1));
    exp_q.push_back(e);
`ifdef WB_ARB_STATS_EN
    if (!r) begin
      mc0 = 0; mc1 = 0; mcc = 0;
    end else begin
      if (m_g0 && mc0 < (1 << CW) - 1) mc0++;
      if (m_g1 && mc1 < (1 << CW) - 1) mc1++;
      if (v0 && v1 && !st && mcc < (1 << CW) - 1) mcc++;
    end
`endif
  endtask

  initial begin : monitor
    wr_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("reg_write", DW'(reg_write), DW'(e.we));
        checkOutput("write_addr", DW'(write_addr), DW'(e.addr));
        checkOutput("write_data", write_data, e.data);
      end
    end
  end

  initial begin : driver
    logic          rv0, rv1, rr, rs;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] rd0, rd1;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 6, 32'h66, 1, 7, 32'h77);
    applyStimulus(1, 0, 1, 5, 32'h11, 0, 0, 0);
    applyStimulus(1, 0, 1, 3, 32'hA, 1, 4, 32'hB);
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 32'hB);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'hFF);
    repeat (3) applyStimulus(1, 1, 1, 7, 32'h70, 1, 8, 32'h80);
    applyStimulus(1, 0, 1, 7, 32'h70, 1, 8, 32'h80);
    applyStimulus(1, 0, 1, 7, 32'h70, 0, 0, 0);
    applyStimulus(1, 0, 1, 9, 32'h99, 0, 0, 0);
    applyStimulus(0, 0, 1, 9, 32'h9A, 1, 10, 32'hAA);
    applyStimulus(1, 0, 1, 9, 32'h9A, 1, 10, 32'hAA);
    applyStimulus(1, 0, 0, 0, 0, 1, 10, 32'hAA);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

    rv0 = 1'b0; rv1 = 1'b0;
    ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(99) != 0);
      rs = ($urandom_range(99) < 15);
      if (!(rv0 && !m_g0)) begin
        rv0 = ($urandom_range(99) < 65);
        ra0 = AW'($urandom_range(1) != 0 ? $urandom_range(3) : $urandom_range(31));
        rd0 = $urandom;
      end
      if (!(rv1 && !m_g1)) begin
        rv1 = ($urandom_range(99) < 65);
        ra1 = AW'($urandom_range(1) != 0 ? $urandom_range(3) : $urandom_range(31));
        rd1 = $urandom;
      end
      applyStimulus(rr, rs, rv0, ra0, rd0, rv1, ra1, rd1);
    end

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
`ifdef WB_ARB_STATS_EN
    checkOutput("grant_cnt0", DW'(grant_cnt0), DW'(mc0));
    checkOutput("grant_cnt1", DW'(grant_cnt1), DW'(mc1));
    checkOutput("conflict_cnt", DW'(conflict_cnt), DW'(mcc));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (reg_write / write_addr / write_data) between two writeback sources.
  - Source 0 (s0) is the ALU result path.
  - Source 1 (s1) is the load / long-latency result path.
- Round-robin arbitration, valid/ready handshake per source, registered write outputs.
- Sits between the execute/memory stages and the regfile write port.

Parameters:
- DATA_WIDTH, 32, width of writeback data.
- ADDR_WIDTH, 5, register address width.
- CNT_WIDTH, 16, width of statistics counters (used only with WB_ARB_STATS_EN).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
- wb_stall  input  1  when high, no source is granted this cycle.
- s0_valid  input  1  ALU writeback request.
- s0_addr  input  ADDR_WIDTH  ALU destination register.
- s0_data  input  DATA_WIDTH  ALU result.
- s0_ready  output  1  s0 granted this cycle (combinational).
- s1_valid  input  1  load/LL writeback request.
- s1_addr  input  ADDR_WIDTH  load destination register.
- s1_data  input  DATA_WIDTH  load result.
- s1_ready  output  1  s1 granted this cycle (combinational).
- reg_write  output  1  registered write enable to regfile.
- write_addr  output  ADDR_WIDTH  registered write address.
- write_data  output  DATA_WIDTH  registered write data.

Behaviour:
- Reset (rst==0 at a clk edge):
  - reg_write=0, write_addr=0, write_data=0.
  - Priority pointer set to s0; stats counters cleared.
  - s0_ready and s1_ready are 0 while rst==0.
- Grant (combinational, same cycle):
  - If wb_stall==1, no grant.
  - Else if exactly one source is valid, grant that source.
  - Else if both are valid, grant the source indicated by the priority pointer.
- Ready: sN_ready = grant_N. A transfer is sN_valid & sN_ready. Sources hold addr/data stable while valid and not ready.
- Priority pointer updates only on a both-valid grant, to point at the loser. A single-valid grant leaves it unchanged.
- Output latency is 1 cycle. On the edge after a transfer:
  - write_addr and write_data take the granted source's values.
  - reg_write = 1 iff granted addr != 0.
- Writes to x0 are accepted (ready asserted, source released) but produce reg_write=0. write_addr/write_data still update.
- No transfer in a cycle → reg_write=0 next cycle; write_addr/write_data hold their values.
- Starvation bound: with wb_stall low, a waiting valid source is granted within 2 cycles.
- Both sources targeting the same register in the same cycle: written in grant order. The later write wins in the regfile.
- wb_stall asserted mid-stream:
  - Grants stop immediately.
  - A write already registered still presents reg_write=1 for its one cycle.
- Reset mid-operation: pending valid requests are ignored; the outstanding registered write is cancelled (reg_write=0).

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0, grant_cnt1, conflict_cnt (each CNT_WIDTH).
  - grant_cnt0 / grant_cnt1 increment on each transfer from s0 / s1.
  - conflict_cnt increments each cycle both sources are valid and wb_stall==0.
  - All three saturate at all-ones and are cleared by reset.
- Undefined: the three ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package wb_arb_pkg:
  - DATA_WIDTH / ADDR_WIDTH defaults.
  - Source-ID constants SRC_ALU=0, SRC_LD=1.
  - X0_ADDR constant.
- Sub-module rr_arbiter2: 2-request round-robin grant plus priority pointer register with stall input. The top level adds the data mux, output register and stats.

Test Plan:
- Reset, then s0_valid=1 addr=5 data=0x11 → s0_ready=1 same cycle; next cycle reg_write=1, write_addr=5, write_data=0x11.
- Both valid (s0: x3=0xA, s1: x4=0xB) for 2 cycles after reset → cycle0 grants s0, cycle1 grants s1; writes x3=0xA then x4=0xB on consecutive cycles.
- s1_valid addr=0 data=0xFF → s1_ready=1; next cycle reg_write=0, write_addr=0, write_data=0xFF.
- wb_stall=1 with both valid for 3 cycles → both readys 0, reg_write 0; release stall → grants resume with the priority pointer unchanged.
- rst=0 asserted while s0_valid=1 and a write is registered → next cycle reg_write=0 and ready=0; after release, s0 is granted first.
- With WB_ARB_STATS_EN and CNT_WIDTH=4: 20 conflict cycles → conflict_cnt saturates at 0xF; grant_cnt0 and grant_cnt1 each equal 10.
